// File: rtl/mem_store_buffer.sv
// mem_store_buffer
// In-order store buffer between the MEM-stage register and a single-port data
// memory. Stores are queued and drained one per cycle into the memory write
// port whenever no load owns the port. Loads whose word address matches any
// queued store (or a store arriving in the same cycle) are stalled until the
// matching entries have drained, so a load never observes stale data.

module mem_store_buffer #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          st_req,
    input  logic [31:0]   st_addr,
    input  logic [31:0]   st_wdata,
    input  logic [1:0]    st_size,
    input  logic [31:0]   st_pc,
    output logic          st_stall,
    input  logic          ld_req,
    input  logic [31:0]   ld_addr,
    output logic          ld_stall,
    output logic [31:0]   dm_add,
    output logic [31:0]   dm_mfw,
    output logic          dm_mw,
    output logic [1:0]    dm_S,
    output logic [31:0]   dm_pc,
    output logic [CW-1:0] sb_count,
    output logic          sb_empty
);

    localparam int PW = $clog2(DEPTH);

    // Entry storage, one array per field
    logic [31:0] addr_mem  [DEPTH];
    logic [31:0] wdata_mem [DEPTH];
    logic [1:0]  size_mem  [DEPTH];
    logic [31:0] pc_mem    [DEPTH];

    // Queue state
    logic [PW-1:0] head_reg, head_next;
    logic [PW-1:0] tail_reg, tail_next;
    logic [CW-1:0] count_reg, count_next;
    logic          empty_reg, empty_next;

    // Per-entry validity and load-address match
    logic [DEPTH-1:0] entry_valid;
    logic [DEPTH-1:0] entry_hit;

    logic full;
    logic incoming_hit;
    logic hit;
    logic load_owns;
    logic enq;
    logic drain;

    // An entry is valid when its distance from head (mod DEPTH) is below count
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [PW-1:0] offset;
            assign offset          = PW'(gi) - head_reg;
            assign entry_valid[gi] = CW'(offset) < count_reg;
            assign entry_hit[gi]   = entry_valid[gi] &&
                                     (addr_mem[gi][31:2] == ld_addr[31:2]);
        end
    endgenerate

    assign full         = (count_reg == CW'(DEPTH));
    assign incoming_hit = st_req && (st_addr[31:2] == ld_addr[31:2]);
    assign hit          = (|entry_hit) || incoming_hit;

    // Reset forces all handshake and write strobes inactive
    assign st_stall  = !reset && st_req && full;
    assign ld_stall  = !reset && ld_req && hit;
    assign load_owns = ld_req && !hit;
    assign enq       = !reset && st_req && !full;
    assign drain     = !reset && !load_owns && (count_reg != '0);

    // Port mux: an unhit load owns the address; otherwise present the head entry
    always_comb begin
        dm_add = load_owns ? ld_addr : addr_mem[head_reg];
        dm_mfw = wdata_mem[head_reg];
        dm_S   = size_mem[head_reg];
        dm_pc  = pc_mem[head_reg];
        dm_mw  = drain;
    end

    // Next-state for pointers and occupancy
    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (enq) begin
            tail_next = tail_reg + 1'b1;
        end
        if (drain) begin
            head_next = head_reg + 1'b1;
        end
        case ({enq, drain})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
        empty_next = (count_next == '0);
    end

    // Queue state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            empty_reg <= 1'b1;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
            empty_reg <= empty_next;
        end
    end

    // Entry write at tail on an accepted store
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_mem[tail_reg]  <= st_addr;
            wdata_mem[tail_reg] <= st_wdata;
            size_mem[tail_reg]  <= st_size;
            pc_mem[tail_reg]    <= st_pc;
        end
    end

    assign sb_count = count_reg;
    assign sb_empty = empty_reg;

endmodule

// File: tb/tb_mem_store_buffer.sv
// Directed testbench for mem_store_buffer.
module tb_mem_store_buffer;

    logic        clk;
    logic        reset;
    logic        st_req;
    logic [31:0] st_addr;
    logic [31:0] st_wdata;
    logic [1:0]  st_size;
    logic [31:0] st_pc;
    logic        st_stall;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic        ld_stall;
    logic [31:0] dm_add;
    logic [31:0] dm_mfw;
    logic        dm_mw;
    logic [1:0]  dm_S;
    logic [31:0] dm_pc;
    logic [2:0]  sb_count;
    logic        sb_empty;

    int total_checks;
    int passed_checks;

    mem_store_buffer #(.DEPTH(4), .CW(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .st_req   (st_req),
        .st_addr  (st_addr),
        .st_wdata (st_wdata),
        .st_size  (st_size),
        .st_pc    (st_pc),
        .st_stall (st_stall),
        .ld_req   (ld_req),
        .ld_addr  (ld_addr),
        .ld_stall (ld_stall),
        .dm_add   (dm_add),
        .dm_mfw   (dm_mfw),
        .dm_mw    (dm_mw),
        .dm_S     (dm_S),
        .dm_pc    (dm_pc),
        .sb_count (sb_count),
        .sb_empty (sb_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_checks++;
        assert (obs === exp) passed_checks++;
        else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
            $error("check %s observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total_checks  = 0;
        passed_checks = 0;
        reset    = 1'b1;
        st_req   = 1'b0;
        st_addr  = '0;
        st_wdata = '0;
        st_size  = '0;
        st_pc    = '0;
        ld_req   = 1'b0;
        ld_addr  = '0;

        // Reset: requests are ignored and strobes forced low
        #1;
        st_req  = 1'b1;
        st_addr = 32'h500;
        ld_req  = 1'b1;
        ld_addr = 32'h500;
        #1;
        $display("txn reset held with st_req/ld_req active");
        chk("rst_dm_mw", 32'(dm_mw), 32'd0);
        chk("rst_st_stall", 32'(st_stall), 32'd0);
        chk("rst_ld_stall", 32'(ld_stall), 32'd0);
        step();
        step();
        reset  = 1'b0;
        st_req = 1'b0;
        ld_req = 1'b0;
        #1;
        $display("txn idle after reset");
        chk("idle_empty", 32'(sb_empty), 32'd1);
        chk("idle_count", 32'(sb_count), 32'd0);
        chk("idle_dm_mw", 32'(dm_mw), 32'd0);
        chk("idle_st_stall", 32'(st_stall), 32'd0);
        chk("idle_ld_stall", 32'(ld_stall), 32'd0);

        // Single store, drained the following cycle
        st_req   = 1'b1;
        st_addr  = 32'h10;
        st_wdata = 32'h12345678;
        st_size  = 2'd3;
        st_pc    = 32'h3000;
        #1;
        $display("txn store addr=0x10 data=0x12345678");
        chk("single_st_stall", 32'(st_stall), 32'd0);
        step();
        st_req = 1'b0;
        #1;
        chk("single_count", 32'(sb_count), 32'd1);
        chk("single_dm_mw", 32'(dm_mw), 32'd1);
        chk("single_dm_add", dm_add, 32'h10);
        chk("single_dm_mfw", dm_mfw, 32'h12345678);
        chk("single_dm_S", 32'(dm_S), 32'd3);
        chk("single_dm_pc", dm_pc, 32'h3000);
        step();
        #1;
        chk("single_empty", 32'(sb_empty), 32'd1);
        chk("single_dm_mw_after", 32'(dm_mw), 32'd0);

        // Fill while an unrelated load owns the port
        ld_req  = 1'b1;
        ld_addr = 32'h100;
        for (int i = 0; i < 4; i++) begin
            st_req   = 1'b1;
            st_addr  = 32'(4 * i);
            st_wdata = 32'hA0 + 32'(i);
            st_size  = 2'd3;
            st_pc    = 32'h4000 + 32'(4 * i);
            #1;
            $display("txn fill store %0d addr=0x%0h with load at 0x100", i, 4 * i);
            chk("fill_dm_mw", 32'(dm_mw), 32'd0);
            chk("fill_dm_add", dm_add, 32'h100);
            chk("fill_ld_stall", 32'(ld_stall), 32'd0);
            chk("fill_st_stall", 32'(st_stall), 32'd0);
            step();
        end
        st_addr  = 32'h10;
        st_wdata = 32'hEE;
        #1;
        $display("txn fifth store against full buffer");
        chk("full_count", 32'(sb_count), 32'd4);
        chk("full_st_stall", 32'(st_stall), 32'd1);
        chk("full_dm_mw", 32'(dm_mw), 32'd0);
        step();
        st_req = 1'b0;
        ld_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            $display("txn drain %0d expect addr=0x%0h", i, 4 * i);
            chk("drain_count", 32'(sb_count), 32'(4 - i));
            chk("drain_dm_mw", 32'(dm_mw), 32'd1);
            chk("drain_dm_add", dm_add, 32'(4 * i));
            chk("drain_dm_mfw", dm_mfw, 32'hA0 + 32'(i));
            chk("drain_dm_pc", dm_pc, 32'h4000 + 32'(4 * i));
            step();
        end
        #1;
        chk("drain_empty", 32'(sb_empty), 32'd1);

        // Load hit on a byte store queued behind three words
        ld_req  = 1'b1;
        ld_addr = 32'h100;
        for (int i = 0; i < 4; i++) begin
            st_req   = 1'b1;
            st_addr  = (i == 3) ? 32'h21 : 32'h50 + 32'(4 * i);
            st_wdata = (i == 3) ? 32'hAB : 32'hB0 + 32'(i);
            st_size  = (i == 3) ? 2'd2 : 2'd3;
            st_pc    = 32'h5000 + 32'(4 * i);
            #1;
            $display("txn hit-setup store addr=0x%0h", st_addr);
            step();
        end
        st_req  = 1'b0;
        ld_addr = 32'h20;
        for (int i = 0; i < 4; i++) begin
            #1;
            $display("txn load 0x20 stalled, draining entry %0d", i);
            chk("hit_ld_stall", 32'(ld_stall), 32'd1);
            chk("hit_dm_mw", 32'(dm_mw), 32'd1);
            chk("hit_dm_add", dm_add, (i == 3) ? 32'h21 : 32'h50 + 32'(4 * i));
            if (i == 3) begin
                chk("hit_dm_mfw", dm_mfw, 32'hAB);
                chk("hit_dm_S", 32'(dm_S), 32'd2);
            end
            step();
        end
        #1;
        $display("txn load 0x20 proceeds");
        chk("hit_clear_ld_stall", 32'(ld_stall), 32'd0);
        chk("hit_clear_dm_mw", 32'(dm_mw), 32'd0);
        chk("hit_clear_dm_add", dm_add, 32'h20);

        // Same-cycle store and load to the same word
        st_req   = 1'b1;
        st_addr  = 32'h40;
        st_wdata = 32'h77;
        st_size  = 2'd3;
        st_pc    = 32'h6000;
        ld_addr  = 32'h43;
        #1;
        $display("txn same-cycle store 0x40 load 0x43");
        chk("same_ld_stall", 32'(ld_stall), 32'd1);
        chk("same_st_stall", 32'(st_stall), 32'd0);
        chk("same_dm_mw", 32'(dm_mw), 32'd0);
        step();
        st_req = 1'b0;
        #1;
        chk("same_q_ld_stall", 32'(ld_stall), 32'd1);
        chk("same_q_dm_mw", 32'(dm_mw), 32'd1);
        chk("same_q_dm_add", dm_add, 32'h40);
        step();
        #1;
        chk("same_clear_ld_stall", 32'(ld_stall), 32'd0);
        chk("same_clear_dm_add", dm_add, 32'h43);
        ld_req = 1'b0;

        // Prime two entries, then enqueue and drain together for 8 cycles
        ld_req  = 1'b1;
        ld_addr = 32'h100;
        for (int i = 0; i < 2; i++) begin
            st_req   = 1'b1;
            st_addr  = 32'h200 + 32'(4 * i);
            st_wdata = 32'hC0 + 32'(i);
            st_pc    = 32'h7000 + 32'(4 * i);
            #1;
            $display("txn prime store addr=0x%0h", st_addr);
            step();
        end
        ld_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            st_req   = 1'b1;
            st_addr  = 32'h208 + 32'(4 * i);
            st_wdata = 32'hC2 + 32'(i);
            st_pc    = 32'h7008 + 32'(4 * i);
            #1;
            $display("txn enq+drain %0d: in 0x%0h, out expected 0x%0h", i, st_addr, 32'h200 + 32'(4 * i));
            chk("steady_count", 32'(sb_count), 32'd2);
            chk("steady_dm_mw", 32'(dm_mw), 32'd1);
            chk("steady_dm_add", dm_add, 32'h200 + 32'(4 * i));
            chk("steady_dm_mfw", dm_mfw, 32'hC0 + 32'(i));
            step();
        end
        st_req = 1'b0;
        for (int i = 8; i < 10; i++) begin
            #1;
            $display("txn tail drain expect data 0x%0h", 32'hC0 + 32'(i));
            chk("steady_tail_dm_mfw", dm_mfw, 32'hC0 + 32'(i));
            chk("steady_tail_dm_pc", dm_pc, 32'h7000 + 32'(4 * i));
            step();
        end
        #1;
        chk("steady_empty", 32'(sb_empty), 32'd1);

        // Reset with three pending stores discards them
        ld_req  = 1'b1;
        ld_addr = 32'h100;
        for (int i = 0; i < 3; i++) begin
            st_req   = 1'b1;
            st_addr  = 32'h300 + 32'(4 * i);
            st_wdata = 32'hD0 + 32'(i);
            #1;
            step();
        end
        st_req = 1'b0;
        ld_req = 1'b0;
        reset  = 1'b1;
        #1;
        $display("txn reset with 3 pending");
        chk("rst3_pre_count", 32'(sb_count), 32'd3);
        chk("rst3_dm_mw", 32'(dm_mw), 32'd0);
        step();
        reset = 1'b0;
        #1;
        $display("txn after reset release");
        chk("rst3_count", 32'(sb_count), 32'd0);
        chk("rst3_empty", 32'(sb_empty), 32'd1);
        chk("rst3_dm_mw", 32'(dm_mw), 32'd0);
        step();
        #1;
        chk("rst3_no_stale_mw", 32'(dm_mw), 32'd0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/mem_store_buffer.md
# mem_store_buffer

Store buffer between the MEM-stage pipeline register and the data memory's single port. It queues store requests (address, data, size code, PC) in program order and drains one per cycle into the memory write port whenever no load needs that port. It also stalls any load whose word address matches a pending or incoming store, so loads never read stale data. Memory write order, and therefore the memory's write log, is identical to unbuffered program order.

## Interface
- DEPTH, 4, number of entries; power of two, ≥2
- CW, 3, count width = log2(DEPTH)+1
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- st_req  in  1  store request from MEM stage
- st_addr  in  32  store byte address
- st_wdata  in  32  store data (byte/half in low bits)
- st_size  in  2  3 = word, 1 = half, 2 = byte, 0 = treated as word
- st_pc  in  32  PC of the store instruction
- st_stall  out  1  store not accepted this cycle
- ld_req  in  1  load request from MEM stage
- ld_addr  in  32  load byte address
- ld_stall  out  1  load must retry next cycle
- dm_add  out  32  memory address (read and write share it)
- dm_mfw  out  32  memory write data
- dm_mw  out  1  memory write enable
- dm_S  out  2  memory store-size code (st_size passed through)
- dm_pc  out  32  PC for the memory write log
- sb_count  out  CW  valid entry count
- sb_empty  out  1  sb_count == 0

## Operation
- Storage: circular FIFO of DEPTH entries {addr, wdata, size, pc}, with head pointer, tail pointer, and count. Pointers wrap modulo DEPTH.
- Enqueue: on a posedge where st_req=1 and st_stall=0, write the entry at tail, then tail+1 and count+1.
- st_stall = st_req && count==DEPTH. A full buffer does not bypass, even if a drain occurs in the same cycle.
- Hit: ld_addr[31:2] equals addr[31:2] of any valid entry, or equals st_addr[31:2] when st_req=1 in the same cycle. Size is ignored; a whole-word match is sufficient.
- ld_stall = ld_req && hit.
- Port arbitration, combinational, per cycle:
  - ld_req=1 and no hit: dm_add = ld_addr, dm_mw = 0. The load owns the port and no drain occurs.
  - Otherwise, including a stalled load: dm_add = head.addr, dm_mfw = head.wdata, dm_S = head.size, dm_pc = head.pc, dm_mw = (count≠0).
- Drain: on a posedge with dm_mw=1, head+1 and count−1. The memory performs the write on that same edge.
- Enqueue and drain in the same cycle: count unchanged; both pointers advance.
- When count=0, dm_add/dm_mfw/dm_S/dm_pc are don't-care and dm_mw=0.
- Stores and loads are independent. If st_req and ld_req are both 1, the store is enqueued (if not full) and the load follows the rules above.

## Timing
- Reset (sync): head = tail = 0, count = 0, entry contents don't-care. While reset=1: dm_mw=0, st_stall=0, ld_stall=0, and st_req is ignored. After the reset edge: sb_empty=1, sb_count=0.
- Reset mid-drain: all pending stores are discarded. The memory is cleared by the same reset.
- st_stall, ld_stall, and all dm_* outputs are combinational from current state and inputs. sb_count and sb_empty are registered state.
- Entry latency: an entry enqueued at edge N is at the earliest written to memory at edge N+1, i.e. presented on dm_* during cycle N..N+1, when it is the head and no unhit load is present.
- A stalled load is retried each cycle. It proceeds in the first cycle its hit clears, which is one cycle after the last matching entry drains. Maximum stall is DEPTH+1 cycles.
- Throughput: one enqueue and one drain per cycle. Continuous unhit loads starve draining indefinitely; that is allowed, and stores then back-pressure via st_stall.

## Test plan
- Reset then idle: sb_empty=1, sb_count=0, dm_mw=0, no stalls.
- Single store: st_addr=0x10, st_wdata=0x12345678, st_size=3, st_pc=0x3000, no loads. Next cycle dm_mw=1, dm_add=0x10, dm_mfw=0x12345678, dm_pc=0x3000. Then sb_empty=1.
- Fill: 4 stores issued while ld_req=1 continuously at unrelated address 0x100. count reaches 4. 5th store -> st_stall=1. Drop ld_req -> drains to 0x0,0x4,0x8,0xC in order, one per cycle.
- Load hit: store byte 0xAB to 0x21 (st_size=2) queued behind 3 entries, then ld_addr=0x20. ld_stall=1 until the 0x21 entry drains; the load proceeds the next cycle. Same-cycle st_req/ld_req with st_addr=0x40, ld_addr=0x43 -> ld_stall=1.
- Simultaneous enqueue+drain for 8 cycles: count stays constant, order preserved, pointer wrap verified.
- Reset asserted with 3 entries pending: dm_mw=0 during reset. Afterwards count=0, and no stale write occurs after reset deasserts.
